// File: rtl/rand_char_source.sv
// Random lowercase-character source: an 8-bit Fibonacci LFSR feeds a show-ahead FIFO,
// one character per level change on tx_rdy, drained by rx_done.
module rand_char_source #(
  parameter logic [7:0] SEED  = 8'hAA,
  parameter int         DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_rdy,
  input  logic                       rx_done,
  output logic                       rx_rdy,
  output logic [7:0]                 out_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 rand_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    lfsr_q;
  logic [7:0]    lfsr_d;
  logic          tx_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [7:0]    new_char;
  logic          wr_stb;
  logic          do_push;
  logic          do_pop;
  logic          is_empty;
  logic          is_full;

  // The all-zero state is a lock-up for this tap set, so it is forced to 8'h01.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (lfsr_q == 8'h00) begin
      lfsr_d = 8'h01;
    end
  end

  assign new_char = 8'h61 + (lfsr_q % 8'd26);

  // Handshake: rx_rdy acts as valid and out_data is the head entry while it is high;
  // rx_done acts as ready, and a pop happens exactly on cycles where both are high.
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_CNT);
  assign wr_stb   = (tx_rdy != tx_q);
  assign do_pop   = rx_done && !is_empty;
  assign do_push  = wr_stb && (!is_full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      tx_q   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      tx_q   <= tx_rdy;
      cnt_q  <= cnt_d;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is left uninitialised; only pointers and count define its valid contents.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= new_char;
    end
  end

  assign rx_rdy   = !is_empty;
  assign full     = is_full;
  assign count    = cnt_q;
  assign out_data = is_empty ? 8'h00 : mem[rd_ptr];
  assign rand_out = lfsr_q;

endmodule

// File: tb/tb_rand_char_source.sv
// Bench for rand_char_source: directed vectors plus randomized traffic against a
// queue-based reference model of the LFSR and FIFO behaviour.
module tb_rand_char_source;

  localparam int         DEPTH = 16;
  localparam logic [7:0] SEED  = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_rdy = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_rdy;
  logic [7:0] out_data;
  logic       full;
  logic [4:0] count;
  logic [7:0] rand_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_lfsr = SEED;
  logic       m_txq  = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rand_char_source #(.SEED(SEED), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_rdy(tx_rdy), .rx_done(rx_done),
    .rx_rdy(rx_rdy), .out_data(out_data), .full(full), .count(count),
    .rand_out(rand_out)
  );

  function automatic logic [7:0] lfsr_ref(input logic [7:0] q);
    int fb;
    if (q == 8'h00) return 8'h01;
    fb = $countones(q & 8'hB8) % 2;
    return 8'(((int'(q) << 1) | fb) & 255);
  endfunction

  function automatic logic [7:0] head_ref();
    if (exp_q.size() == 0) return 8'h00;
    return exp_q[0];
  endfunction

  // Apply inputs for one cycle, advance the model, then move to just after the edge.
  task automatic step(input logic tx, input logic done);
    logic       strobe;
    logic       p_pop;
    logic       p_push;
    logic [7:0] ch;
    tx_rdy  = tx;
    rx_done = done;
    if (rst) begin
      m_lfsr = SEED;
      m_txq  = 1'b0;
      exp_q.delete();
    end else begin
      strobe = (tx != m_txq);
      p_pop  = done && (exp_q.size() > 0);
      p_push = strobe && ((exp_q.size() < DEPTH) || p_pop);
      ch     = 8'(97 + (int'(m_lfsr) % 26));
      if (p_pop) void'(exp_q.pop_front());
      if (p_push) exp_q.push_back(ch);
      m_txq  = tx;
      m_lfsr = lfsr_ref(m_lfsr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({rx_rdy, full, count, out_data, rand_out} !== {1'b0, 1'b0, 5'd0, 8'h00, 8'hAA}) begin
      n_fail++;
      $display("FAIL reset: rx_rdy=%b full=%b count=%0d out=%h rand=%h, want 0 0 0 00 aa",
               rx_rdy, full, count, out_data, rand_out);
    end
  endtask

  task automatic test_lfsr_seq();
    logic [7:0] want [3];
    want[0] = 8'hAA; want[1] = 8'h55; want[2] = 8'hAB;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rand_out !== want[i] || rx_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL lfsr_seq[%0d]: rand=%h rx_rdy=%b, want %h 0", i, rand_out, rx_rdy, want[i]);
      end
      step(1'b0, 1'b0);
    end
  endtask

  task automatic test_first_write();
    do_reset();
    step(1'b1, 1'b0);
    n_tests++;
    if (rx_rdy !== 1'b1 || out_data !== 8'h6F || count !== 5'd1) begin
      n_fail++;
      $display("FAIL first_write: rx_rdy=%b out=%h count=%0d, want 1 6f 1", rx_rdy, out_data, count);
    end
  endtask

  task automatic test_three_writes();
    logic [7:0] want [3];
    want[0] = 8'h6F; want[1] = 8'h68; want[2] = 8'h70;
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_tests++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL three_writes_count: count=%0d, want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_data !== want[i] || rx_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL three_writes_pop[%0d]: out=%h rx_rdy=%b, want %h 1", i, out_data, rx_rdy, want[i]);
      end
      step(1'b1, 1'b1);
    end
    n_tests++;
    if (rx_rdy !== 1'b0 || count !== 5'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL three_writes_drained: rx_rdy=%b count=%0d out=%h, want 0 0 00", rx_rdy, count, out_data);
    end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < 17; i++) step(~tx_rdy, 1'b0);
    n_tests++;
    if (count !== 5'd16 || full !== 1'b1 || exp_q.size() != 16) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d full=%b, want 16 1", count, full);
    end
    step(~tx_rdy, 1'b1);
    n_tests++;
    if (count !== 5'd16 || full !== 1'b1 || out_data !== head_ref()) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d full=%b out=%h, want 16 1 %h", count, full, out_data, head_ref());
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (out_data !== head_ref()) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: out=%h, want %h", i, out_data, head_ref());
      end
      step(tx_rdy, 1'b1);
    end
    n_tests++;
    if (count !== 5'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained: count=%0d full=%b, want 0 0", count, full);
    end
  endtask

  task automatic test_empty_pop_and_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_tests++;
    if (count !== 5'd0 || rx_rdy !== 1'b0 || out_data !== 8'h00 || rand_out !== m_lfsr) begin
      n_fail++;
      $display("FAIL empty_pop: count=%0d rx_rdy=%b out=%h rand=%h, want 0 0 00 %h",
               count, rx_rdy, out_data, rand_out, m_lfsr);
    end
    // Net growth of one entry every other cycle pushes well past DEPTH writes.
    for (int i = 0; i < 2 * (DEPTH + 4); i++) begin
      step(~tx_rdy, (i % 2 == 1));
      n_tests++;
      if (out_data !== head_ref() || count !== 5'(exp_q.size())) begin
        n_fail++;
        $display("FAIL wrap[%0d]: out=%h count=%0d, want %h %0d", i, out_data, count, head_ref(), exp_q.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(~tx_rdy, 1'b0);
    n_tests++;
    if (count !== 5'd5) begin
      n_fail++;
      $display("FAIL mid_reset_setup: count=%0d, want 5", count);
    end
    rst = 1'b1;
    step(~tx_rdy, 1'b1);
    rst = 1'b0;
    n_tests++;
    if (count !== 5'd0 || rx_rdy !== 1'b0 || rand_out !== 8'hAA || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d rx_rdy=%b rand=%h out=%h, want 0 0 aa 00",
               count, rx_rdy, rand_out, out_data);
    end
  endtask

  task automatic test_random();
    logic tx;
    logic done;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tx   = 1'($urandom_range(0, 1));
      done = ($urandom_range(0, 99) < 40);
      step(tx, done);
      n_tests++;
      if ({count, full, rx_rdy, out_data, rand_out} !==
          {5'(exp_q.size()), exp_q.size() == DEPTH, exp_q.size() != 0, head_ref(), m_lfsr}) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d full=%b rx_rdy=%b out=%h rand=%h, want %0d %b %b %h %h",
                 i, count, full, rx_rdy, out_data, rand_out, exp_q.size(),
                 exp_q.size() == DEPTH, exp_q.size() != 0, head_ref(), m_lfsr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_first_write();
    test_three_writes();
    test_fill_full();
    test_empty_pop_and_wrap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
